instr_sequencer: RTL and testbench

Instruction sequencer for the 16-bit processor. It buffers instructions pushed by a host through a valid/ready handshake in a small FIFO and presents them one at a time on `instruction`, holding each stable for exactly 4 clock cycles. It also drives the control unit's active-low reset so that the control unit's free-running cycle counter starts at phase 0 on the first execute cycle of every instruction burst. It sits between the host/program loader and `control_unit`.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/instr_fifo.sv | 70 +++++++
 rtl/instr_sequencer.sv | 140 ++++++++++++++
 tb/tb_instr_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer.
// Contents:
//   state_t          - sequencer FSM states (IDLE, EXEC)
//   CYCLES_PER_INSTR - execute cycles per instruction (control unit counter period)
//   OP_*             - 3-bit opcodes of the 16-bit processor, held in instruction[15:13]
package seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam int CYCLES_PER_INSTR = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NAN = 3'b010;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_REP = 3'b111;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous DEPTH x INSTR_W FIFO with a registered occupancy count.
// Ports:
//   clock, resetn - rising-edge clock, synchronous active-low reset (flushes pointers/count)
//   push, wdata   - write request and data; ignored while full
//   pop, rdata    - read request; rdata always shows the head entry (show-ahead)
//   full, empty   - occupancy flags decoded from the count
//   count         - number of occupied entries, 0..DEPTH
module instr_fifo #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 16
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [INSTR_W-1:0]       wdata,
  output logic [INSTR_W-1:0]       rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import seq_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer increments wrap on their own.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers host instructions in a FIFO and presents each
// one on `instruction` for CYCLES_PER_INSTR cycles, releasing the control unit
// reset so its free-running counter is at phase 0 on every instruction's first cycle.
// Ports:
//   clock, resetn        - rising-edge clock, synchronous active-low reset
//   in_instr/in_valid/in_ready - host push handshake (in_ready = !full && resetn)
//   run                  - level; permits fetching the next instruction
//   instruction          - current instruction to the control unit
//   cu_resetn            - control unit reset, low while idle
//   phase                - execute phase 0..3
//   instr_start/instr_done - high in first / last phase of an instruction
//   busy                 - executing
//   fifo_count           - occupied FIFO entries
//   step                 - single-step request (only when SEQ_STEP_EN is defined)
// Build option: define SEQ_STEP_EN to add the `step` port.
module instr_sequencer #(
  parameter int DEPTH            = 4,
  parameter int INSTR_W          = 16,
  parameter int CYCLES_PER_INSTR = seq_pkg::CYCLES_PER_INSTR
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [INSTR_W-1:0]     in_instr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   run,
  output logic [INSTR_W-1:0]     instruction,
  output logic                   cu_resetn,
  output logic [1:0]             phase,
  output logic                   instr_start,
  output logic                   instr_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef SEQ_STEP_EN
  ,
  input  logic                   step
`endif
);
  import seq_pkg::*;

  localparam logic [1:0] LAST_PHASE = 2'(CYCLES_PER_INSTR - 1);

  state_t             state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               cu_resetn_q, cu_resetn_d;

  logic               fifo_full, fifo_empty;
  logic [INSTR_W-1:0] fifo_rdata;
  logic               push, pop;
  logic               fetch_idle, fetch_last;

  assign in_ready = !fifo_full && resetn;
  assign push     = in_valid && in_ready;

  // A step request only starts an instruction from IDLE; continuing past the
  // last phase always needs run.
`ifdef SEQ_STEP_EN
  assign fetch_idle = (run || step) && !fifo_empty;
`else
  assign fetch_idle = run && !fifo_empty;
`endif
  assign fetch_last = run && !fifo_empty;

  instr_fifo #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (in_instr),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    instr_d     = instr_q;
    cu_resetn_d = cu_resetn_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_idle) begin
          pop         = 1'b1;
          state_d     = EXEC;
          phase_d     = '0;
          instr_d     = fifo_rdata;
          cu_resetn_d = 1'b1;
        end
      end
      EXEC: begin
        if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          if (fetch_last) begin
            // Back-to-back: cu_resetn stays high, control unit counter wraps to 0.
            pop     = 1'b1;
            instr_d = fifo_rdata;
          end else begin
            state_d     = IDLE;
            cu_resetn_d = 1'b0;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        phase_d     = '0;
        cu_resetn_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      instr_q     <= '0;
      cu_resetn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      instr_q     <= instr_d;
      cu_resetn_q <= cu_resetn_d;
    end
  end

  assign instruction = instr_q;
  assign cu_resetn   = cu_resetn_q;
  assign phase       = phase_q;
  assign busy        = (state_q == EXEC);
  assign instr_start = busy && (phase_q == 2'd0);
  assign instr_done  = busy && (phase_q == LAST_PHASE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios followed by
// random traffic, every cycle compared against a queue-based reference model.
// Build option: define SEQ_STEP_EN to exercise the single-step port.
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int CYC   = 4;

  logic        clock;
  logic        resetn;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        run;
  logic        step;
  logic [15:0] instruction;
  logic        cu_resetn;
  logic [1:0]  phase;
  logic        instr_start;
  logic        instr_done;
  logic        busy;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending instructions and cycles left in the current one.
  logic [15:0] mq[$];
  int          rem;
  logic [15:0] m_instr;

  instr_sequencer #(
    .DEPTH            (DEPTH),
    .INSTR_W          (16),
    .CYCLES_PER_INSTR (CYC)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .in_instr    (in_instr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .run         (run),
    .instruction (instruction),
    .cu_resetn   (cu_resetn),
    .phase       (phase),
    .instr_start (instr_start),
    .instr_done  (instr_done),
    .busy        (busy),
    .fifo_count  (fifo_count)
`ifdef SEQ_STEP_EN
    ,
    .step        (step)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    bit rdy;
    bit go;
    bit step_eff;
    rdy = resetn && (mq.size() < DEPTH);
`ifdef SEQ_STEP_EN
    step_eff = step;
`else
    step_eff = 1'b0;
`endif
    if (!resetn) begin
      mq.delete();
      rem     = 0;
      m_instr = '0;
    end else begin
      if (rem > 1) begin
        rem--;
      end else begin
        go = (run || (rem == 0 && step_eff)) && (mq.size() > 0);
        if (go) begin
          m_instr = mq.pop_front();
          rem     = CYC;
        end else begin
          rem = 0;
        end
      end
      if (in_valid && rdy) mq.push_back(in_instr);
    end
  endtask

  task automatic check_outputs();
    chk("instruction", 32'(instruction), 32'(m_instr));
    chk("phase",       32'(phase),       (rem > 0) ? 32'(CYC - rem) : 32'd0);
    chk("cu_resetn",   32'(cu_resetn),   32'(rem > 0));
    chk("busy",        32'(busy),        32'(rem > 0));
    chk("instr_start", 32'(instr_start), 32'(rem == CYC));
    chk("instr_done",  32'(instr_done),  32'(rem == 1));
    chk("fifo_count",  32'(fifo_count),  32'(mq.size()));
    chk("in_ready",    32'(in_ready),    32'(resetn && (mq.size() < DEPTH)));
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    in_valid = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_instr = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    in_instr = '0;
    in_valid = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    rem      = 0;
    m_instr  = '0;

    // Reset values
    do_reset();
    chk("rst_ready_low", 32'(in_ready), 32'd0);
    #2;
    chk("rst_ready_high", 32'(in_ready), 32'd1);

    // Single instruction with run high
    run      = 1'b1;
    in_valid = 1'b1;
    in_instr = {OP_LDI, 13'h0};
    tick();
    in_valid = 1'b0;
    tick();
    chk("s1_instr", 32'(instruction), 32'hA000);
    chk("s1_cu_resetn", 32'(cu_resetn), 32'd1);
    chk("s1_phase0", 32'(phase), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("s1_idle_cu_resetn", 32'(cu_resetn), 32'd0);
    chk("s1_hold_instr", 32'(instruction), 32'hA000);

    // Three queued, then run: 12 back-to-back cycles
    run = 1'b0;
    push_n(3);
    run = 1'b1;
    for (int i = 0; i < 14; i++) tick();

    // Fill past DEPTH with run low; fifth entry is held
    run = 1'b0;
    push_n(4);
    in_valid = 1'b1;
    in_instr = {OP_REP, 13'h1234};
    tick();
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(fifo_count), 32'd4);
    run = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Drop run in phase 1 with 2 queued
    do_reset();
    push_n(3);
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("runlow_busy", 32'(busy), 32'd0);
    chk("runlow_count", 32'(fifo_count), 32'd2);

    // Reset in phase 2 with 3 queued
    do_reset();
    push_n(4);
    run = 1'b1;
    tick();
    tick();
    tick();
    resetn = 1'b0;
    tick();
    chk("midrst_cu_resetn", 32'(cu_resetn), 32'd0);
    chk("midrst_instr", 32'(instruction), 32'd0);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    run    = 1'b0;
    tick();

`ifdef SEQ_STEP_EN
    // Single step
    push_n(2);
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("step_count", 32'(fifo_count), 32'd1);
    chk("step_idle", 32'(busy), 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      resetn   = ($urandom_range(0, 99) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_instr = 16'($urandom);
      if ((i / 40) % 3 == 2) run = 1'b0;
      else                   run = ($urandom_range(0, 3) != 0);
      step     = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
